// File: rtl/lsu_mc.sv
// lsu_mc: single-outstanding load/store unit bridging a core request port to an
// SRAM-style bus with separate address (addr_ok) and data (data_ok) handshakes.
// Handles alignment checking, byte strobes, store-lane replication, load-lane
// extraction with sign/zero extension, and an optional address/data timeout.
module lsu_mc #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [1:0]          data_sram_size,
    output logic [DATA_W/8-1:0] data_sram_wstrb,
    output logic [ADDR_W-1:0]   data_sram_addr,
    output logic [DATA_W-1:0]   data_sram_wdata,
    input  logic                data_sram_addr_ok,
    input  logic                data_sram_data_ok,
    input  logic [DATA_W-1:0]   data_sram_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Count value seen during the TIMEOUT-th busy cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                lat_we, lat_sext;
    logic [1:0]          lat_size;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                accept, legal, misaligned, busy, timeout_hit;
    logic [NB-1:0]       size_mask, wstrb_c;
    logic [DATA_W-1:0]   wdata_c, load_raw, load_ext;
    logic                load_sign;

    assign accept      = (state_q == S_IDLE) && req_valid;
    assign busy        = (state_q == S_ADDR) || (state_q == S_DATA);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Legality of the incoming request: natural alignment and a size the bus supports.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
        legal = !misaligned && !((req_size == 2'd3) && (DATA_W == 32));
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
        end
    end

    // Next-state logic; timeout beats addr_ok, but data_ok beats timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = legal ? S_ADDR : S_RESP;
            S_ADDR: begin
                if (timeout_hit)            state_d = S_RESP;
                else if (data_sram_addr_ok) state_d = S_DATA;
            end
            S_DATA: begin
                if (data_sram_data_ok || timeout_hit) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, timeout counter and response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_we    <= 1'b0;
            lat_sext  <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_sext  <= req_sext;
                lat_size  <= req_size;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt_q     <= '0;
                if (!legal) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end else if (busy) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if ((state_q == S_DATA) && data_sram_data_ok) begin
                rdata_q <= lat_we ? '0 : load_ext;
                err_q   <= 1'b0;
            end else if (busy && timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Byte strobes: 2^size contiguous lanes starting at the address offset.
    always_comb begin
        size_mask = '0;
        for (int i = 0; i < NB; i++) size_mask[i] = (i < (1 << lat_size));
        wstrb_c = lat_we ? (size_mask << lat_addr[OFF_W-1:0]) : '0;
    end

    // Store data: the low 2^size bytes replicated across every lane.
    always_comb begin
        wdata_c = '0;
        for (int b = 0; b < NB; b++) begin
            case (lat_size)
                2'd0:    wdata_c[b*8 +: 8] = lat_wdata[7:0];
                2'd1:    wdata_c[b*8 +: 8] = lat_wdata[(b % 2)*8 +: 8];
                2'd2:    wdata_c[b*8 +: 8] = lat_wdata[(b % 4)*8 +: 8];
                default: wdata_c[b*8 +: 8] = lat_wdata[b*8 +: 8];
            endcase
        end
    end

    // Load data: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        load_raw = data_sram_rdata >> {lat_addr[OFF_W-1:0], 3'b000};
        case (lat_size)
            2'd0:    load_sign = load_raw[7];
            2'd1:    load_sign = load_raw[15];
            2'd2:    load_sign = load_raw[31];
            default: load_sign = load_raw[DATA_W-1];
        endcase
        load_ext = '0;
        for (int i = 0; i < DATA_W; i++)
            load_ext[i] = (i < (8 << lat_size)) ? load_raw[i] : (lat_sext & load_sign);
    end

    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = (state_q == S_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_err        = err_q;
    assign data_sram_req   = (state_q == S_ADDR);
    assign data_sram_wr    = lat_we;
    assign data_sram_size  = lat_size;
    assign data_sram_addr  = lat_addr;
    assign data_sram_wstrb = wstrb_c;
    assign data_sram_wdata = wdata_c;

endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: randomized self-checking bench for lsu_mc (DATA_W=32, TIMEOUT=4).
// Each transaction runs in a fixed 15-cycle window; the expected response cycle,
// bus fields and load data come from a transaction-level model.
module tb_lsu_mc;

    localparam int TO = 4;

    logic        clk, resetn;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        addr_ok, data_ok;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mc #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_size          (req_size),
        .req_sext          (req_sext),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_err          (resp_err),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] bus, input logic [31:0] addr,
                                             input logic [1:0] size, input logic sext);
        int          bits;
        logic [31:0] v, mask, r;
        bits = 8 << size;
        v    = bus >> (8 * (addr % 4));
        mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        r    = v & mask;
        if (sext && v[bits-1]) r = r | ~mask;
        return r;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] size);
        int          nbytes;
        logic [31:0] r;
        nbytes = 1 << size;
        r = '0;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % nbytes) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic we, input logic [31:0] addr, input logic [1:0] size);
        int nbytes;
        nbytes = 1 << size;
        return we ? 4'(((32'd1 << nbytes) - 32'd1) << (addr % 4)) : 4'b0000;
    endfunction

    // One access. ad/dd: extra wait cycles before addr_ok / data_ok.
    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ad, input int dd, input logic [31:0] rd, input logic stray);
        logic        legal, tmo;
        int          exp_resp_cyc, exp_req_cnt;
        logic [31:0] exp_rd;
        int          n_resp, resp_cyc, req_cnt;
        logic        err_s, ready_in_resp;
        logic [31:0] rdata_s, addr_s, wdata_s;
        logic [1:0]  size_s;
        logic        wr_s;
        logic [3:0]  wstrb_s;
        int          acyc, dcyc;

        // Transaction-level expectation.
        legal = ((addr & ((32'd1 << size) - 32'd1)) == 0) && (size != 2'd3);
        acyc  = 1 + ad;
        dcyc  = 2 + ad + dd;
        if (!legal) begin
            tmo = 1'b0; exp_resp_cyc = 1; exp_req_cnt = 0;
        end else if (ad + 1 >= TO) begin
            tmo = 1'b1; exp_resp_cyc = TO + 1; exp_req_cnt = TO;
        end else if (ad + dd + 2 <= TO) begin
            tmo = 1'b0; exp_resp_cyc = ad + dd + 3; exp_req_cnt = ad + 1;
        end else begin
            tmo = 1'b1; exp_resp_cyc = TO + 1; exp_req_cnt = ad + 1;
        end
        exp_rd = (legal && !tmo && !we) ? exp_load(rd, addr, size, sext) : 32'd0;

        // Cycle 0: present the request.
        check("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Fields after acceptance must not matter.
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_sext = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

        n_resp = 0; resp_cyc = -1; req_cnt = 0; err_s = 1'b0; rdata_s = '0;
        ready_in_resp = 1'b1; addr_s = '0; wdata_s = '0; size_s = '0; wr_s = 1'b0; wstrb_s = '0;
        for (int c = 1; c <= 14; c++) begin
            addr_ok   = (c == acyc);
            data_ok   = (c == dcyc) || (stray && (c <= acyc) && ($urandom_range(0, 2) == 0));
            bus_rdata = (c == dcyc) ? rd : $urandom;
            if (data_sram_req) begin
                if (req_cnt == 0) begin
                    addr_s = data_sram_addr; wdata_s = data_sram_wdata; size_s = data_sram_size;
                    wr_s = data_sram_wr; wstrb_s = data_sram_wstrb;
                end
                req_cnt++;
            end
            if (resp_valid) begin
                if (n_resp == 0) begin
                    resp_cyc = c; err_s = resp_err; rdata_s = resp_rdata; ready_in_resp = req_ready;
                end
                n_resp++;
            end
            @(posedge clk); #1;
        end
        addr_ok = 1'b0; data_ok = 1'b0;

        check("resp_count", n_resp, 1);
        check("resp_cycle", resp_cyc, exp_resp_cyc);
        check("resp_err", err_s, !legal || tmo);
        check("resp_rdata", rdata_s, exp_rd);
        check("ready_in_resp", ready_in_resp, 1'b0);
        check("req_cycles", req_cnt, exp_req_cnt);
        if (legal) begin
            check("bus_addr", addr_s, addr);
            check("bus_size", size_s, size);
            check("bus_wr", wr_s, we);
            check("bus_wstrb", wstrb_s, exp_wstrb(we, addr, size));
            check("bus_wdata", wdata_s, exp_wdata(wdata, size));
        end
    endtask

    initial begin
        int saw_resp;
        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0; addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = '0;

        #3;
        check("rst_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_sram_req", data_sram_req, 1'b0);
        check("rst_wstrb", data_sram_wstrb, 4'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_txn(1'b0, 2'd2, 1'b1, 32'h1C00_0004, 32'd0, 0, 0, 32'h8000_00F0, 1'b0);
        run_txn(1'b1, 2'd0, 1'b0, 32'h1C00_0003, 32'h0000_00AB, 0, 0, 32'd0, 1'b0);
        run_txn(1'b0, 2'd1, 1'b1, 32'h1C00_0002, 32'd0, 0, 0, 32'h8001_1234, 1'b0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h1C00_0002, 32'd0, 0, 0, 32'h8001_1234, 1'b0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h1C00_0002, 32'd0, 0, 0, 32'h1234_5678, 1'b0);
        run_txn(1'b0, 2'd3, 1'b0, 32'h1C00_0000, 32'd0, 0, 0, 32'h1234_5678, 1'b0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h1C00_0008, 32'd0, 6, 0, 32'hDEAD_BEEF, 1'b0);
        run_txn(1'b0, 2'd0, 1'b1, 32'h1C00_0001, 32'd0, 1, 1, 32'h0000_8000, 1'b0);
        run_txn(1'b1, 2'd1, 1'b0, 32'h1C00_0006, 32'h0000_BEEF, 0, 3, 32'd0, 1'b0);

        // Reset pulsed while the access sits in the data phase.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0100;
        @(posedge clk); #1;
        req_valid = 1'b0; addr_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_sram_req", data_sram_req, 1'b0);
        check("mid_rst_addr", data_sram_addr, 32'd0);
        check("mid_rst_rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        saw_resp = 0;
        for (int c = 0; c < 4; c++) begin
            data_ok = 1'b1; bus_rdata = $urandom;
            if (resp_valid) saw_resp++;
            @(posedge clk); #1;
        end
        data_ok = 1'b0;
        check("mid_rst_no_resp", saw_resp, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 0, 0, 32'hCAFE_F00D, 1'b0);

        // Randomized accesses.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 255), 2'b00} | 32'h1C00_0000 | 32'($urandom_range(0, 3));
            run_txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mc.md
LSU_MC -- requirements
Module: lsu_mc

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus data width; legal values 32 or 64; byte lanes NB = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the cycle limit awaiting data_ok; 0 disables the timeout.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk, input, 1, the single clock, rising edge.
REQ-006 Port resetn, input, 1, asynchronous active-low reset.
REQ-007 Port req_valid, input, 1, core access request.
REQ-008 Port req_ready, output, 1, high exactly in IDLE.
REQ-009 Port req_we, input, 1, 1 = store, 0 = load.
REQ-010 Port req_size, input, 2, 0 byte / 1 half / 2 word / 3 dword.
REQ-011 Port req_sext, input, 1, load sign-extend enable.
REQ-012 Port req_addr, input, ADDR_W, byte address.
REQ-013 Port req_wdata, input, DATA_W, store data, right-aligned.
REQ-014 Port resp_valid, output, 1, one-cycle completion pulse.
REQ-015 Port resp_rdata, output, DATA_W, extended load data (0 for stores and errors).
REQ-016 Port resp_err, output, 1, misaligned, illegal size, or timeout.
REQ-017 Ports data_sram_req, data_sram_wr, and data_sram_size, outputs, 1/1/2: bus request, write flag, and size.
REQ-018 Ports data_sram_wstrb, data_sram_addr, and data_sram_wdata, outputs, NB/ADDR_W/DATA_W: byte strobes, address, and lane-placed data.
REQ-019 Ports data_sram_addr_ok, data_sram_data_ok, and data_sram_rdata, inputs, 1/1/DATA_W: address accepted, data phase done, and read data.

Function
REQ-020 SHALL implement states IDLE, ADDR, DATA, and RESP, with one outstanding access maximum.
REQ-021 Acceptance SHALL occur when req_valid && req_ready; all req_* fields latch on that edge and later changes to them are ignored.
REQ-022 Legality check at acceptance: the access is illegal if req_addr mod 2^size ≠ 0, or if size=3 with DATA_W=32.
REQ-023 An illegal access SHALL go IDLE->RESP with no bus request, resp_err=1, and resp_rdata=0.
REQ-024 A legal access SHALL go IDLE->ADDR; data_sram_req stays high throughout ADDR and is registered, first high the cycle after acceptance.
REQ-025 In ADDR, data_sram_addr_ok=1 SHALL move the block to DATA and drop data_sram_req the following cycle.
REQ-026 data_sram_data_ok SHALL be honoured only in DATA; data_ok in any other state SHALL be ignored.
REQ-027 In DATA, data_ok=1 SHALL latch the extracted load data and move the block to RESP.
REQ-028 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-029 Minimum latency SHALL be 3 cycles from the acceptance edge to resp_valid, with addr_ok on the first req cycle and data_ok on the next.
REQ-030 data_sram_addr SHALL carry the latched address unmodified; data_sram_size SHALL equal the latched size.
REQ-031 wstrb SHALL be ((1<<2^size)-1) << addr[log2(NB)-1:0] for stores and all-zero for loads.
REQ-032 wdata SHALL replicate req_wdata's low 2^size bytes across all lanes.
REQ-033 Load extraction SHALL take 2^size bytes starting at lane addr[log2(NB)-1:0], then sign-extend (req_sext=1) or zero-extend to DATA_W.
REQ-034 Timeout counter: cleared on entering ADDR and incremented each cycle in ADDR or DATA.
REQ-035 If TIMEOUT≠0 and the count reaches TIMEOUT, the block SHALL go to RESP with resp_err=1 and rdata=0, and drop data_sram_req.
REQ-036 If data_ok and timeout coincide, data_ok SHALL win and resp_err=0.
REQ-037 req_ready SHALL be 0 during RESP; a new request can be accepted the cycle after resp_valid at the earliest.

Reset
REQ-038 resetn=0 SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, and data_sram_req=0, with all bus outputs 0 and the counter 0.
REQ-039 Reset asserted mid-access SHALL abandon the access with no response; after release the first cycle is IDLE.

Verification
REQ-040 Word load, addr 0x1C000004, addr_ok on the first req cycle, data_ok next with rdata 0x8000_00F0, sext=1 -> resp_valid 3 cycles after acceptance, rdata=0x8000_00F0, err=0.
REQ-041 Byte store, addr 0x...3, wdata 0xAB, DATA_W=32 -> wstrb=4'b1000, bus wdata=0xABABABAB, size=0, wr=1.
REQ-042 Half load, addr 0x...2, rdata 0x8001_1234, sext=1 -> 0xFFFF8001; with sext=0 -> 0x00008001.
REQ-043 Word load at addr 0x...2 -> no data_sram_req ever, resp_valid 1 cycle after acceptance with err=1; size=3 with DATA_W=32 gives the same result.
REQ-044 TIMEOUT=4, addr_ok withheld -> req drops and resp err=1 after 4 counted cycles; a late data_ok in IDLE produces no response.
REQ-045 resetn pulsed low while in DATA -> outputs reach reset values asynchronously; a subsequent load completes normally.
